crkt_sweep_ctrl: RTL

- Sequencer that exhaustively exercises a small combinational circuit-under-test, such as the 3-input a/b/c → y lab circuits.
- Drives every input vector in ascending binary order and holds each one for a programmable dwell time.
- Samples y at the end of each dwell, builds the measured truth table, and compares it against a latched expected table.
- Sits between a board-level start button/switch bank and the combinational CUT; reports pass/fail and the first failing vector.

---
 rtl/crkt_sweep_pkg.sv | 21 ++
 rtl/crkt_sweep_ctrl_dwell_timer.sv | 48 ++++
 rtl/crkt_sweep_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/crkt_sweep_pkg.sv
// rtl/crkt_sweep_pkg.sv - shared types and defaults for the truth-table sweep controller
//
// Purpose: sweep FSM state type, default sizing, and the vector-count helper.
// Ports:   none (package).
package crkt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } sweep_state_t;

  localparam int N_IN_DEF  = 3;
  localparam int DWELL_DEF = 4;

  // Number of input vectors for an n-input circuit.
  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/crkt_sweep_ctrl_dwell_timer.sv
// rtl/crkt_sweep_ctrl_dwell_timer.sv - per-vector dwell counter with terminal-count flag
//
// Purpose: counts clock edges while a vector is held; tc marks the sampling edge.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - force the count to zero (held while not sweeping)
//   en   - advance the count
//   tc   - high while the count equals DWELL-1
module sweep_dwell_timer
  import crkt_sweep_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wraps to zero on the terminal count so consecutive vectors need no extra clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/crkt_sweep_ctrl.sv
// rtl/crkt_sweep_ctrl.sv - exhaustive truth-table sweeper for a small combinational circuit
//
// Purpose: walks every input vector in ascending order, holds each for DWELL cycles,
//          samples y on the last dwell edge, and compares against a latched golden table.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   start           - sweep request, honoured only when idle
//   expected        - golden truth table (bit i = expected y for vector i)
//   y_in            - circuit output
//   vec             - circuit input vector
//   busy            - high while sweeping
//   done            - one-cycle pulse at sweep completion
//   pass            - last completed sweep had no mismatches
//   truth           - measured truth table
//   mismatch_count  - mismatches in current/last sweep
//   first_fail_idx  - first mismatching vector (valid with fail_seen)
//   fail_seen       - at least one mismatch in this sweep
module crkt_sweep_ctrl
  import crkt_sweep_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [vec_count(N_IN)-1:0] expected,
  input  logic                       y_in,
  output logic [N_IN-1:0]            vec,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [vec_count(N_IN)-1:0] truth,
  output logic [N_IN:0]              mismatch_count,
  output logic [N_IN-1:0]            first_fail_idx,
  output logic                       fail_seen
);

  localparam int              NV       = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   truth_q, truth_d;
  logic [N_IN:0]   mm_q, mm_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            fs_q, fs_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tc;

  sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk (clk),
    .rst (reset),
    .clr (state_q != SETTLE),
    .en  (1'b1),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    truth_d = truth_q;
    mm_d    = mm_q;
    ffi_d   = ffi_q;
    fs_d    = fs_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          exp_d   = expected;
          truth_d = '0;
          mm_d    = '0;
          ffi_d   = '0;
          fs_d    = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (tc) begin
          truth_d[idx_q] = y_in;
          if (y_in != exp_q[idx_q]) begin
            mm_d = mm_q + (N_IN + 1)'(1);
            if (!fs_q) begin
              ffi_d = idx_q;
              fs_d  = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            // pass must reflect the final sample, so use the updated count
            pass_d  = (mm_d == '0);
            state_d = DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      truth_q <= '0;
      mm_q    <= '0;
      ffi_q   <= '0;
      fs_q    <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      truth_q <= truth_d;
      mm_q    <= mm_d;
      ffi_q   <= ffi_d;
      fs_q    <= fs_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vec            = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth          = truth_q;
  assign mismatch_count = mm_q;
  assign first_fail_idx = ffi_q;
  assign fail_seen      = fs_q;

endmodule
